event_timestamper: RTL and testbench



---
 rtl/ts_pkg.sv | 25 ++
 rtl/ts_fifo.sv | 82 ++++++++
 rtl/event_timestamper.sv | 88 ++++++++
 tb/tb_event_timestamper.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared constants and helpers for the event timestamper.
// Optional drop counter is enabled with TS_DROP_CNT_EN.
package ts_pkg;

  localparam int DEFAULT_DWIDTH = 8;
  localparam int DEFAULT_DEPTH  = 8;
  localparam int DROP_CNT_W     = 8;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  typedef struct packed {
    logic wr;
    logic rd;
    logic drop;
  } fifo_acc_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through timestamp storage.
// Holds pointers, level and simultaneous-access rules.
module ts_fifo
  import ts_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level,
  output logic              drop
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  fifo_acc_t         acc;
  lvl_op_e           lvl_op;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // Resolve which accesses are taken this cycle.
  always_comb begin
    acc      = '0;
    acc.rd   = rd_en & ~empty;
    acc.wr   = wr & (~full | acc.rd);
    acc.drop = wr & full & ~acc.rd;
  end

  assign drop = acc.drop;

  // Pick the level update from the accepted accesses.
  always_comb begin
    lvl_op = LVL_HOLD;
    unique case (1'b1)
      (acc.wr & ~acc.rd): lvl_op = LVL_INC;
      (acc.rd & ~acc.wr): lvl_op = LVL_DEC;
      default:            lvl_op = LVL_HOLD;
    endcase
  end

  // Storage has no reset; contents behind empty are never shown.
  always_ff @(posedge clk) begin
    if (acc.wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and level counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (acc.wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (acc.rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (lvl_op)
        LVL_INC:  level <= level + LW'(1);
        LVL_DEC:  level <= level - LW'(1);
        default:  level <= level;
      endcase
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/event_timestamper.sv
// Stamps armed rising edges of event_in with counter_in.
// Define TS_DROP_CNT_EN to add the saturating drop_cnt output.
module event_timestamper
  import ts_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] counter_in,
  input  logic              event_in,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [DWIDTH-1:0] ts_out,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level,
  output logic              overflow
`ifdef TS_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic event_q;
  logic rise;
  logic armed;
  logic wr;
  logic drop;

  // Previous event level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_q <= 1'b0;
    end else begin
      event_q <= event_in;
    end
  end

  assign rise  = event_in & ~event_q;
  assign armed = (counter_in != '0);
  assign wr    = rise & armed;

  ts_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .wdata  (counter_in),
    .rd_en  (rd_en),
    .rdata  (ts_out),
    .empty  (empty),
    .full   (full),
    .level  (level),
    .drop   (drop)
  );

  // Sticky overflow; a new drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef TS_DROP_CNT_EN
  // Saturating count of dropped stamps since the last clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`else
  // Without the counter, overflow alone reports drops.
`endif

endmodule

// File: tb/tb_event_timestamper.sv
// Scoreboard bench for event_timestamper.
// Honours TS_DROP_CNT_EN for the optional drop counter.
module tb_event_timestamper;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [DW-1:0] counter_in;
  logic          event_in;
  logic          rd_en;
  logic          clr_ovf;
  logic [DW-1:0] ts_out;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef TS_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb[$];
  logic          m_ovf;
  logic          m_evq;
  int            m_dcnt;

  event_timestamper #(
    .DWIDTH (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .counter_in (counter_in),
    .event_in   (event_in),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .ts_out     (ts_out),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overflow   (overflow)
`ifdef TS_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle at negedge, update the model, wait for next negedge.
  task automatic step(input logic r, input logic ev,
                      input logic [DW-1:0] cnt,
                      input logic re, input logic co);
    logic rise_m, wr_m, rd_m, drop_m;
    logic [DW-1:0] tmp;
    rst = r;
    event_in = ev;
    counter_in = cnt;
    rd_en = re;
    clr_ovf = co;
    if (r) begin
      sb.delete();
      m_ovf = 1'b0;
      m_evq = 1'b0;
      m_dcnt = 0;
    end else begin
      rise_m = ev & ~m_evq;
      wr_m = rise_m & (cnt != 0);
      rd_m = re & (sb.size() != 0);
      drop_m = wr_m & (sb.size() == DEPTH) & ~rd_m;
      if (rd_m) tmp = sb.pop_front();
      if (wr_m && !drop_m) sb.push_back(cnt);
      if (co) m_dcnt = drop_m ? 1 : 0;
      else if (drop_m && m_dcnt < 255) m_dcnt++;
      if (drop_m) m_ovf = 1'b1;
      else if (co) m_ovf = 1'b0;
      m_evq = ev;
    end
    @(negedge clk);
  endtask

  task automatic pulse(input logic [DW-1:0] cnt);
    step(0, 1, cnt, 0, 0);
    step(0, 0, cnt, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty got=%b exp=1", empty);
    end
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL reset_level got=%0d exp=0", level);
    end
    checks++;
    if (ts_out !== '0) begin
      errors++;
      $display("FAIL reset_ts got=%h exp=00", ts_out);
    end
    checks++;
    if (overflow !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b exp=00", overflow, full);
    end
  endtask

  task automatic test_disarmed();
    for (int i = 0; i < 5; i++) pulse(8'h00);
    checks++;
    if (empty !== 1'b1 || level !== '0) begin
      errors++;
      $display("FAIL disarmed_empty got=%b/%0d exp=1/0", empty, level);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL disarmed_ovf got=%b exp=0", overflow);
    end
  endtask

  task automatic test_order();
    logic [DW-1:0] vals [3];
    vals[0] = 8'h05;
    vals[1] = 8'h09;
    vals[2] = 8'h20;
    for (int i = 0; i < 3; i++) pulse(vals[i]);
    checks++;
    if (level !== LW'(3)) begin
      errors++;
      $display("FAIL order_level got=%0d exp=3", level);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ts_out !== vals[i] || ts_out !== sb[0]) begin
        errors++;
        $display("FAIL order_ts%0d got=%h exp=%h", i, ts_out, vals[i]);
      end
      step(0, 0, 8'h40, 1, 0);
    end
    checks++;
    if (empty !== 1'b1 || ts_out !== '0) begin
      errors++;
      $display("FAIL order_drain got=%b/%h exp=1/00", empty, ts_out);
    end
  endtask

  task automatic test_empty_rw();
    step(0, 1, 8'h11, 1, 0);
    checks++;
    if (level !== LW'(sb.size()) || ts_out !== 8'h11) begin
      errors++;
      $display("FAIL empty_rw got=%0d/%h exp=1/11", level, ts_out);
    end
    step(0, 0, 8'h11, 1, 0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw_pop got=%b exp=1", empty);
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) pulse(DW'(i));
    checks++;
    if (full !== 1'b1 || level !== LW'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_full got=%b/%0d exp=1/8", full, level);
    end
    checks++;
    if (overflow !== m_ovf || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got=%b exp=1", overflow);
    end
    checks++;
    if (ts_out !== 8'h01) begin
      errors++;
      $display("FAIL ovf_head got=%h exp=01", ts_out);
    end
`ifdef TS_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'(m_dcnt) || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ovf_dcnt got=%0d exp=1", drop_cnt);
    end
`endif
  endtask

  task automatic test_full_rw();
    step(0, 1, 8'h40, 1, 0);
    step(0, 0, 8'h40, 0, 0);
    checks++;
    if (level !== LW'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_rw got=%0d/%b exp=8/1", level, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ts_out !== sb[0]) begin
        errors++;
        $display("FAIL full_rw_ts%0d got=%h exp=%h", i, ts_out, sb[0]);
      end
      if (i == DEPTH - 1) begin
        checks++;
        if (ts_out !== 8'h40) begin
          errors++;
          $display("FAIL full_rw_tail got=%h exp=40", ts_out);
        end
      end
      step(0, 0, 8'h40, 1, 0);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_rw_drain got=%b exp=1", empty);
    end
  endtask

  task automatic test_clr_ovf();
    step(0, 0, 8'h01, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf got=%b exp=0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) pulse(DW'(8'h60 + i));
    step(0, 1, 8'h77, 0, 1);
    step(0, 0, 8'h77, 0, 0);
    checks++;
    if (overflow !== 1'b1 || overflow !== m_ovf) begin
      errors++;
      $display("FAIL set_wins got=%b exp=1", overflow);
    end
`ifdef TS_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL set_wins_dcnt got=%0d exp=1", drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(0, 0, 8'h01, 1, 0);
    checks++;
    if (level !== LW'(4) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got=%0d/%b exp=4/1", level, overflow);
    end
    step(1, 0, 8'h01, 0, 0);
    step(0, 0, 8'h01, 0, 0);
    checks++;
    if (empty !== 1'b1 || level !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%b/%0d/%b exp=1/0/0",
               empty, level, overflow);
    end
    pulse(8'h33);
    checks++;
    if (level !== LW'(1) || ts_out !== 8'h33) begin
      errors++;
      $display("FAIL mid_stamp got=%0d/%h exp=1/33", level, ts_out);
    end
    step(0, 0, 8'h33, 1, 0);
  endtask

  task automatic test_first_after_reset();
    step(1, 1, 8'h44, 0, 0);
    step(0, 1, 8'h44, 0, 0);
    step(0, 1, 8'h45, 0, 0);
    checks++;
    if (level !== LW'(1) || ts_out !== 8'h44) begin
      errors++;
      $display("FAIL first_rise got=%0d/%h exp=1/44", level, ts_out);
    end
    step(0, 0, 8'h45, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      step(0, logic'(i % 2 == 0), DW'(8'h50 + i), 0, 0);
    checks++;
    if (level !== LW'(4) || level !== LW'(sb.size())) begin
      errors++;
      $display("FAIL b2b_level got=%0d exp=4", level);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ts_out !== DW'(8'h50 + 2 * k)) begin
        errors++;
        $display("FAIL b2b_ts%0d got=%h exp=%h", k, ts_out,
                 DW'(8'h50 + 2 * k));
      end
      step(0, 0, 8'h01, 1, 0);
    end
  endtask

  task automatic test_window_boundary();
    step(0, 0, 8'hFE, 0, 0);
    step(0, 1, 8'hFF, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h01, 0, 0);
    checks++;
    if (level !== LW'(1) || ts_out !== 8'hFF) begin
      errors++;
      $display("FAIL window got=%0d/%h exp=1/ff", level, ts_out);
    end
    step(0, 0, 8'h01, 1, 0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL window_drain got=%b exp=1", empty);
    end
  endtask

  initial begin
    rst = 1'b1;
    event_in = 1'b0;
    counter_in = '0;
    rd_en = 1'b0;
    clr_ovf = 1'b0;
    m_ovf = 1'b0;
    m_evq = 1'b0;
    m_dcnt = 0;
    @(negedge clk);
    test_reset();
    test_disarmed();
    test_order();
    test_empty_rw();
    test_overflow();
    test_full_rw();
    test_clr_ovf();
    test_reset_mid();
    test_first_after_reset();
    test_back_to_back();
    test_window_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
